vga_text_scanner: RTL and testbench
===================================

Name: vga_text_scanner

Overview:
- Display-side consumer of the 4800-byte character VRAM (80 columns x 60 rows, one byte per cell).
- Generates 640x480@60 VGA timing and walks the VRAM read port in raster order.
- Each character code is looked up in an external 8x8 font ROM, and the glyph row is serialised into 12-bit RGB pixels.
- Sits between the VRAM read-only port and the board VGA pins.
- Also produces a one-cycle frame-start pulse for the CPU/kernel side.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- COLS, 80, character cells per row (equals H_VIS/8)
- FG_RGB, 12'hFFF, foreground colour {r,g,b}
- BG_RGB, 12'h000, background colour

Ports:
- clk  in  1  pixel clock, 25 MHz nominal; the only clock
- rst  in  1  synchronous, active-high reset
- ro_addr  out  13  VRAM read address
- ro_rdata  in  8  VRAM read data; combinational, same cycle as ro_addr
- font_addr  out  11  font ROM address {char[7:0], glyph_row[2:0]}
- font_data  in  8  font ROM data; combinational, same cycle; bit 7 is the leftmost pixel
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- frame_start  out  1  one-cycle pulse at the first visible pixel of each frame

Behaviour:
- Counters: h_cnt runs 0..799 (H total = 800) and wraps to 0. v_cnt increments when h_cnt wraps, runs 0..524 (V total = 525) and wraps to 0 when both counters are at their maximum.
- Stage 0 (counter cycle T):
  - visible = (h_cnt < H_VIS) && (v_cnt < V_VIS).
  - ro_addr is combinational: (v_cnt>>3)*COLS + (h_cnt>>3) when visible, else 0. Range 0..4799; it never exceeds 4799.
- Stage 1 (T+1):
  - Registers: char_q <= ro_rdata; h1 <= h_cnt[2:0]; vr1 <= v_cnt[2:0]; vis1 <= visible.
  - Sync/blank terms are registered alongside.
  - font_addr = {char_q, vr1}, combinational.
- Stage 2 (T+2): registers glyph_q <= font_data; h2 <= h1; vis2 <= vis1.
- Stage 3 (T+3), registered outputs:
  - {vga_r,vga_g,vga_b} = vis2 ? (glyph_q[7-h2] ? FG_RGB : BG_RGB) : 12'h000.
  - vga_hs = 0 iff h_cnt at T was in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656,751].
  - vga_vs = 0 iff v_cnt at T was in [490,491].
- Latency: total latency from counter to pins is exactly 3 cycles for pixels, hs and vs alike. All three are delayed through the same pipeline, so they stay mutually aligned.
- frame_start: 1 for exactly one cycle, the cycle the pixel for (h,v)=(0,0) appears on the pins (3 cycles after the counters read 0,0). Otherwise 0.
- Blanking: RGB is forced to 0 whenever the source pixel is outside the visible region, including during the porches and sync.
- Glyph timing: the glyph is fetched once per 8-pixel cell, but ro_addr is re-driven every cycle. Since ro_addr is constant across a cell, this is harmless, and no cell-level caching is required.
- VRAM writes: the block never writes VRAM. A CPU write landing mid-frame becomes visible on the next scan of that cell; tearing is acceptable.
- Reset (sync, active-high):
  - h_cnt = v_cnt = 0.
  - All pipeline registers cleared, with vis1 and vis2 = 0.
  - vga_r/g/b = 0; vga_hs = vga_vs = 1 (inactive); frame_start = 0.
  - ro_addr = 0 and font_addr = 0 (char_q = 0).
- Reset released: counters start at (0,0) on the first cycle after rst is deasserted. The first frame_start and first visible pixel appear on the pins 3 cycles later.
- Reset mid-frame: output is blanked immediately (next edge), with no partial sync pulses extended. The frame then restarts from (0,0) as above.
- Reset asserted for 1 cycle is sufficient.

Test Plan:
- Reset then run 420,000 cycles -> hs low for 96 cycles every 800. First hs falling edge at cycle 656+3 after reset release. vs low for exactly 1600 cycles (2 lines) every 420,000 cycles.
- Behavioural VRAM with mem[0]=8'h41 and a font ROM returning 8'b1000_0001 for char 0x41 row 0 -> pins at cycles 3..10 after release show FFF,000,000,000,000,000,000,FFF. frame_start is high only at cycle 3.
- Addressing: mem[4799]=8'h7F; sweep the frame -> ro_addr==4799 occurs only at h_cnt 632..639, v_cnt 472..479. ro_addr is never >4799 and is 0 during blanking. font_addr = {8'h7F,3'd0}..{8'h7F,3'd7} on the matching lines.
- Blanking: font_data tied 8'hFF -> RGB==FFF on all 307,200 visible pixels and 0 on all others, checked with a 3-cycle-aligned scoreboard.
- Mid-frame reset: assert rst at v_cnt=200, h_cnt=700 for 1 cycle -> next edge RGB=0, hs=vs=1, frame_start=0. frame_start re-fires 3 cycles after release and hs timing restarts from h=0.
- Wrap: run 2 full frames -> frame_start pulses exactly 420,000 cycles apart. v_cnt wraps 524->0 in the same cycle h_cnt wraps 799->0.

Source files
------------

// File: rtl/vga_text_scanner.sv
// 80x60 text-mode scanner: 640x480@60 timing, VRAM walk, font lookup and pixel serialisation.
// Pixels, syncs and frame_start all travel the same three-register pipeline, so they stay aligned on the pins.
module vga_text_scanner #(
  parameter int          H_VIS  = 640,
  parameter int          H_FP   = 16,
  parameter int          H_SYNC = 96,
  parameter int          H_BP   = 48,
  parameter int          V_VIS  = 480,
  parameter int          V_FP   = 10,
  parameter int          V_SYNC = 2,
  parameter int          V_BP   = 33,
  parameter int          COLS   = 80,
  parameter logic [11:0] FG_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [12:0] ro_addr,
  input  logic [7:0]  ro_rdata,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VIS);
  localparam logic [9:0] V_VIS_END = 10'(V_VIS);
  localparam logic [9:0] H_SYNC_LO = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_LO = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [7:0]  char_q, char_d, glyph_q, glyph_d;
  logic [2:0]  h1_q, h1_d, vr1_q, vr1_d, h2_q, h2_d;
  logic        vis1_q, vis1_d, vis2_q, vis2_d;
  logic        hs1_q, hs1_d, hs2_q, hs2_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic        fs1_q, fs1_d, fs2_q, fs2_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;

  logic        visible, in_hsync, in_vsync, at_origin;
  logic [12:0] row_base, cell_addr;

  assign visible   = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
  assign in_hsync  = (h_cnt_q >= H_SYNC_LO) && (h_cnt_q <= H_SYNC_HI);
  assign in_vsync  = (v_cnt_q >= V_SYNC_LO) && (v_cnt_q <= V_SYNC_HI);
  assign at_origin = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

  assign row_base  = 13'(v_cnt_q[9:3]) * 13'(COLS);
  assign cell_addr = row_base + {6'd0, h_cnt_q[9:3]};
  assign ro_addr   = visible ? cell_addr : 13'd0;
  assign font_addr = {char_q, vr1_q};

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 10'd0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end

    char_d  = ro_rdata;
    h1_d    = h_cnt_q[2:0];
    vr1_d   = v_cnt_q[2:0];
    vis1_d  = visible;
    hs1_d   = in_hsync;
    vs1_d   = in_vsync;
    fs1_d   = at_origin;

    glyph_d = font_data;
    h2_d    = h1_q;
    vis2_d  = vis1_q;
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
    fs2_d   = fs1_q;

    // Glyph bit 7 is the leftmost pixel of the cell.
    rgb_d   = 12'h000;
    if (vis2_q) rgb_d = glyph_q[3'd7 - h2_q] ? FG_RGB : BG_RGB;
    hs_d    = ~hs2_q;
    vs_d    = ~vs2_q;
    fs_d    = fs2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      char_q  <= '0;
      h1_q    <= '0;
      vr1_q   <= '0;
      vis1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      fs1_q   <= 1'b0;
      glyph_q <= '0;
      h2_q    <= '0;
      vis2_q  <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      fs2_q   <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      char_q  <= char_d;
      h1_q    <= h1_d;
      vr1_q   <= vr1_d;
      vis1_q  <= vis1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      fs1_q   <= fs1_d;
      glyph_q <= glyph_d;
      h2_q    <= h2_d;
      vis2_q  <= vis2_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      fs2_q   <= fs2_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
    end
  end

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_text_scanner.sv
// Bench for vga_text_scanner: behavioural VRAM and font ROM, 3-deep scoreboard of expected pins.
// Vertical geometry is shortened (20 lines, 16 visible) so a whole frame is 16000 cycles.
module tb_vga_text_scanner;

  localparam int TB_V_VIS  = 16;
  localparam int TB_V_FP   = 1;
  localparam int TB_V_SYNC = 2;
  localparam int TB_V_BP   = 1;
  localparam int V_TOT     = TB_V_VIS + TB_V_FP + TB_V_SYNC + TB_V_BP;
  localparam int FRAME     = 800 * V_TOT;
  localparam int LAST_CELL = (TB_V_VIS / 8 - 1) * 80 + 79;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;
  localparam exp_t IDLE = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic        clk, rst;
  logic [12:0] ro_addr;
  logic [7:0]  ro_rdata;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start;
  logic [11:0] rgb;

  logic [7:0]  mem [0:4799];
  logic        font_ff;
  exp_t        sb[$];
  int          mh, mv;
  logic [7:0]  p_char;
  logic [2:0]  p_vr;
  int          n_cmp, n_bad;

  function automatic logic [7:0] font_fn(input logic [7:0] c, input logic [2:0] r);
    if (c == 8'h41 && r == 3'd0) return 8'b1000_0001;
    return c ^ {r, r[1:0], r};
  endfunction

  assign ro_rdata  = (ro_addr < 13'd4800) ? mem[ro_addr] : 8'h00;
  assign font_data = font_ff ? 8'hFF : font_fn(font_addr[10:3], font_addr[2:0]);
  assign rgb       = {vga_r, vga_g, vga_b};

  vga_text_scanner #(
    .V_VIS (TB_V_VIS),
    .V_FP  (TB_V_FP),
    .V_SYNC(TB_V_SYNC),
    .V_BP  (TB_V_BP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ro_addr    (ro_addr),
    .ro_rdata   (ro_rdata),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Called at a negedge: checks the combinational ports against the model counters,
  // queues the pins this position must produce three edges later, pops and compares
  // the entry due now, then advances one clock.
  task automatic step();
    exp_t       e, g;
    logic       vis;
    int         a;
    logic [7:0] gl;
    vis = (mh < 640) && (mv < TB_V_VIS);
    a   = vis ? (mv / 8) * 80 + mh / 8 : 0;
    n_cmp++;
    if (ro_addr !== 13'(a)) begin
      n_bad++;
      $display("FAIL ro_addr h=%0d v=%0d: got %0d expected %0d", mh, mv, ro_addr, a);
    end
    n_cmp++;
    if (font_addr !== {p_char, p_vr}) begin
      n_bad++;
      $display("FAIL font_addr h=%0d v=%0d: got %h expected %h", mh, mv, font_addr, {p_char, p_vr});
    end
    gl    = font_ff ? 8'hFF : font_fn(mem[a], 3'(mv));
    e.rgb = vis ? (gl[7 - (mh % 8)] ? 12'hFFF : 12'h000) : 12'h000;
    e.hs  = !(mh >= 656 && mh <= 751);
    e.vs  = !(mv >= TB_V_VIS + TB_V_FP && mv < TB_V_VIS + TB_V_FP + TB_V_SYNC);
    e.fs  = (mh == 0) && (mv == 0);
    sb.push_back(e);
    g = sb.pop_front();
    n_cmp++;
    if (rgb !== g.rgb) begin
      n_bad++;
      $display("FAIL rgb at h=%0d v=%0d: got %h expected %h", mh, mv, rgb, g.rgb);
    end
    n_cmp++;
    if (vga_hs !== g.hs) begin
      n_bad++;
      $display("FAIL vga_hs at h=%0d v=%0d: got %b expected %b", mh, mv, vga_hs, g.hs);
    end
    n_cmp++;
    if (vga_vs !== g.vs) begin
      n_bad++;
      $display("FAIL vga_vs at h=%0d v=%0d: got %b expected %b", mh, mv, vga_vs, g.vs);
    end
    n_cmp++;
    if (frame_start !== g.fs) begin
      n_bad++;
      $display("FAIL frame_start at h=%0d v=%0d: got %b expected %b", mh, mv, frame_start, g.fs);
    end
    p_char = mem[a];
    p_vr   = 3'(mv);
    if (mh == 799) begin
      mh = 0;
      mv = (mv == V_TOT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    repeat (3) sb.push_back(IDLE);
    mh = 0;
    mv = 0;
    p_char = 8'h00;
    p_vr = 3'd0;
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    apply_reset();
    n_cmp++;
    if (rgb !== 12'h000) begin n_bad++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
    n_cmp++;
    if ({vga_hs, vga_vs} !== 2'b11) begin n_bad++; $display("FAIL reset_sync: got %b expected 11", {vga_hs, vga_vs}); end
    n_cmp++;
    if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
    n_cmp++;
    if (ro_addr !== 13'd0 || font_addr !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_addr: got ro=%0d font=%h expected 0/0", ro_addr, font_addr);
    end
  endtask

  task automatic test_first_cell();
    logic [11:0] px_exp [8];
    px_exp = '{12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF};
    font_ff = 1'b0;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      if (k >= 3 && k <= 10) begin
        n_cmp++;
        if (rgb !== px_exp[k-3]) begin
          n_bad++;
          $display("FAIL first_cell cycle %0d: got %h expected %h", k, rgb, px_exp[k-3]);
        end
      end
      n_cmp++;
      if (frame_start !== (k == 3)) begin
        n_bad++;
        $display("FAIL first_cell_fs cycle %0d: got %b expected %b", k, frame_start, (k == 3));
      end
      step();
    end
  endtask

  task automatic test_hsync();
    int   fall1, fall2, low_len;
    logic prev;
    fall1 = -1; fall2 = -1; low_len = 0; prev = 1'b1;
    apply_reset();
    for (int k = 0; k < 1700; k++) begin
      if (prev && !vga_hs) begin
        if (fall1 < 0) fall1 = k;
        else if (fall2 < 0) fall2 = k;
      end
      if (!vga_hs && fall2 < 0) low_len++;
      prev = vga_hs;
      step();
    end
    n_cmp++;
    if (fall1 != 659) begin n_bad++; $display("FAIL hs_first_fall: got %0d expected 659", fall1); end
    n_cmp++;
    if (fall2 != 1459) begin n_bad++; $display("FAIL hs_second_fall: got %0d expected 1459", fall2); end
    n_cmp++;
    if (low_len != 96) begin n_bad++; $display("FAIL hs_width: got %0d expected 96", low_len); end
  endtask

  task automatic test_addressing();
    int n_last, n_font, max_a;
    n_last = 0; n_font = 0; max_a = 0;
    for (int i = 0; i < 4800; i++) begin
      mem[i] = 8'($urandom_range(0, 254));
      if (mem[i] >= 8'h7F) mem[i] = mem[i] + 8'd1;
    end
    mem[LAST_CELL] = 8'h7F;
    font_ff = 1'b0;
    apply_reset();
    for (int k = 0; k < FRAME; k++) begin
      if (int'(ro_addr) == LAST_CELL) n_last++;
      if (int'(ro_addr) > max_a) max_a = int'(ro_addr);
      if (font_addr[10:3] == 8'h7F) n_font++;
      step();
    end
    n_cmp++;
    if (n_last != 64) begin n_bad++; $display("FAIL last_cell_hits: got %0d expected 64", n_last); end
    n_cmp++;
    if (max_a != LAST_CELL) begin n_bad++; $display("FAIL max_addr: got %0d expected %0d", max_a, LAST_CELL); end
    n_cmp++;
    if (n_font != 64) begin n_bad++; $display("FAIL last_char_font: got %0d expected 64", n_font); end
  endtask

  task automatic test_mid_reset();
    int   fall1, guard;
    logic prev;
    font_ff = 1'b1;
    apply_reset();
    guard = 0;
    while (!(mh == 700 && mv == 10) && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    n_cmp++;
    if (guard >= 2 * FRAME) begin n_bad++; $display("FAIL mid_reset_reach: got %0d cycles expected < %0d", guard, 2 * FRAME); end
    apply_reset();
    n_cmp++;
    if (rgb !== 12'h000) begin n_bad++; $display("FAIL mid_reset_rgb: got %h expected 000", rgb); end
    n_cmp++;
    if ({vga_hs, vga_vs, frame_start} !== 3'b110) begin
      n_bad++;
      $display("FAIL mid_reset_ctl: got %b expected 110", {vga_hs, vga_vs, frame_start});
    end
    fall1 = -1; prev = 1'b1;
    for (int k = 0; k < 700; k++) begin
      n_cmp++;
      if (frame_start !== (k == 3)) begin
        n_bad++;
        $display("FAIL mid_reset_fs cycle %0d: got %b expected %b", k, frame_start, (k == 3));
      end
      if (prev && !vga_hs && fall1 < 0) fall1 = k;
      prev = vga_hs;
      step();
    end
    n_cmp++;
    if (fall1 != 659) begin n_bad++; $display("FAIL mid_reset_hs_fall: got %0d expected 659", fall1); end
  endtask

  task automatic test_wrap();
    int fs_at[$];
    int n_fff, n_vs;
    n_fff = 0; n_vs = 0;
    font_ff = 1'b1;
    apply_reset();
    for (int k = 0; k < 2 * FRAME + 10; k++) begin
      if (frame_start === 1'b1) fs_at.push_back(k);
      if (k < FRAME && rgb === 12'hFFF) n_fff++;
      if (k < FRAME && vga_vs === 1'b0) n_vs++;
      step();
    end
    n_cmp++;
    if (fs_at.size() != 3) begin
      n_bad++;
      $display("FAIL fs_count: got %0d expected 3", fs_at.size());
    end else begin
      n_cmp++;
      if (fs_at[0] != 3) begin n_bad++; $display("FAIL fs_first: got %0d expected 3", fs_at[0]); end
      n_cmp++;
      if (fs_at[1] - fs_at[0] != FRAME) begin
        n_bad++; $display("FAIL fs_period1: got %0d expected %0d", fs_at[1] - fs_at[0], FRAME);
      end
      n_cmp++;
      if (fs_at[2] - fs_at[1] != FRAME) begin
        n_bad++; $display("FAIL fs_period2: got %0d expected %0d", fs_at[2] - fs_at[1], FRAME);
      end
    end
    n_cmp++;
    if (n_fff != 640 * TB_V_VIS) begin n_bad++; $display("FAIL fg_pixels: got %0d expected %0d", n_fff, 640 * TB_V_VIS); end
    n_cmp++;
    if (n_vs != 800 * TB_V_SYNC) begin n_bad++; $display("FAIL vs_width: got %0d expected %0d", n_vs, 800 * TB_V_SYNC); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    font_ff = 1'b0;
    for (int i = 0; i < 4800; i++) mem[i] = 8'h00;
    mem[0] = 8'h41;
    @(negedge clk);
    test_reset();
    test_first_cell();
    test_hsync();
    test_addressing();
    test_mid_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
